dac_spi_multi: RTL and testbench
================================

# dac_spi_multi

Parametrised multi-channel SPI front end for the board's 32-bit-frame serial DAC (LTC2624 family). The host writes channel values into a shadow register bank. A round-robin scheduler sends every changed channel as a write-and-update frame over an integrated SPI shifter with a configurable SCK divider. The block captures the DAC's echoed readback word. It sits between application logic (waveform generators, test sequencers) and the DAC pins on the 50 MHz clock.

## Interface
- CHANNELS, 4, number of DAC channels; legal 2..15. Channel index i maps to DAC address i.
- DATA_W, 12, sample width; legal 8..16.
- SCK_DIV, 2, SCK half-period in clock cycles; legal 1..255.
- CMD, 4'b0011, command nibble sent in every frame (write and update).

- CLK50MHZ  in  1  system clock
- RST  in  1  reset; asynchronous, active-low
- wr_en  in  1  write strobe for one cycle
- wr_all  in  1  with wr_en: write wr_data to every channel
- wr_ch  in  CH_W=$clog2(CHANNELS)  target channel when wr_all=0
- wr_data  in  DATA_W  channel value
- pending  out  CHANNELS  dirty vector; bit i means channel i is not yet sent
- busy  out  1  frame in progress, from CS fall to end of GAP
- done  out  1  one-cycle pulse at frame end
- done_ch  out  CH_W  channel of the frame that just finished; valid with done
- readback  out  32  word shifted in from DAC_OUT; updated with done
- DAC_CS  out  1  chip select, active-low
- DAC_CLR  out  1  DAC clear, active-low
- SPI_SCK  out  1  serial clock, idle low
- SPI_MOSI  out  1  serial data out
- DAC_OUT  in  1  serial data from DAC (MISO)

## Operation
- Frame, MSB first: {8'h00, CMD, addr[3:0], wr_data, (16-DATA_W) zeros}.
- **Write:** wr_en stores the value in the shadow register and sets its pending bit. A write to a channel that is already pending overwrites the value; only one frame is sent (coalescing). wr_ch ≥ CHANNELS is ignored.
- **Write during send:** if a channel's frame is in flight and it is written in the same cycle its pending bit would clear, set wins. The new value is sent in a later frame. The frame in flight keeps the value latched at SETUP entry.
- **Scheduler:** in IDLE, pick the first pending channel at or after rr_ptr, wrapping around. Set rr_ptr to that channel + 1, mod CHANNELS. Clear that channel's pending bit on SETUP entry.
- **FSM states:**
  - IDLE: CS=1, SCK=0. Moves to SETUP when any pending bit is set.
  - SETUP: CS=0, MOSI=bit31, lasts one half-period.
  - SHIFT: 64 half-periods. SCK rises on odd half-periods, falls on even ones. DAC_OUT is sampled on the cycle SCK rises. MOSI advances on each falling edge.
  - HOLD: SCK=0, lasts one half-period.
  - GAP: CS=1, lasts 2 half-periods, then returns to IDLE.
- **DAC_CLR:** registered; 0 while RST=0, 1 from the first clock edge after reset release.

## Timing
- **Reset values:** DAC_CS=1, SPI_SCK=0, SPI_MOSI=0, DAC_CLR=0, busy=0, done=0, pending=0, readback=0, rr_ptr=0, shadow values=0.
- **Reset mid-frame:** CS rises immediately (asynchronous). Pending bits and the frame in flight are lost. No done pulse.
- wr_en at clock edge 0 → DAC_CS low after edge 1.
- CS low to CS high: 66·SCK_DIV cycles. done, done_ch and readback update on the cycle CS rises.
- Frame period: 68·SCK_DIV cycles, i.e. 136 cycles at SCK_DIV=2.
- **Setup/hold:** MOSI is stable ≥1 half-period before and after each SCK rise. First SCK rise is one half-period after CS falls. CS rises one half-period after the last SCK fall.
- pending reflects a write on the cycle after wr_en.

## Structure
- Package dac_spi_pkg holds: the FSM state enum, CMD_* localparams (write, update, write-and-update, power-down), ADDR_ALL=4'hF, FRAME_W=32.
- One sub-module, spi_shift32: divider, SCK generation, 32-bit shift-out and shift-in, start/done handshake. The top level holds the shadow bank, pending vector, round-robin arbiter and frame assembly.

## Test plan
- **Single write:** ch2 = 12'hABC, SCK_DIV=2 → one frame 0x0032ABC0, CS low for 132 cycles, done with done_ch=2, pending returns to 0.
- **Coalescing:** three writes to ch1 (0x111, 0x222, 0x333) while ch0's frame is in flight → exactly one ch1 frame, carrying 0x333.
- **Write during own frame:** write ch3 = 0x555 mid-frame of ch3 = 0x444 → frame 0x444 completes, then a second frame 0x555.
- **Round-robin:** wr_all with 0x7FF, CHANNELS=4 → frames in order 0,1,2,3, consecutive CS falls 136 cycles apart. A new write to ch0 during ch1's frame is served after ch3.
- **Readback:** bench DAC model echoes the previous frame on DAC_OUT → readback of frame n equals the MOSI word of frame n−1.
- **Reset mid-SHIFT:** pull RST low at half-period 20 → CS=1, DAC_CLR=0 in the same cycle, no done. After release: IDLE, pending=0, DAC_CLR=1 one edge later.

Source files
------------

// File: rtl/dac_spi_pkg.sv
// Shared types and constants for the multi-channel LTC2624-style DAC front end.
package dac_spi_pkg;

  localparam int FRAME_W = 32;

  // Command nibbles understood by the DAC
  localparam logic [3:0] CMD_WRITE        = 4'b0000;
  localparam logic [3:0] CMD_UPDATE       = 4'b0001;
  localparam logic [3:0] CMD_WRITE_UPDATE = 4'b0011;
  localparam logic [3:0] CMD_POWER_DOWN   = 4'b0100;

  // Broadcast address; never produced by the scheduler since channel count stays below 16
  localparam logic [3:0] ADDR_ALL = 4'hF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_SHIFT,
    ST_HOLD,
    ST_GAP
  } spi_state_t;

  // 32-bit frame: 8 don't-care bits, command, address, left-justified sample
  function automatic logic [FRAME_W-1:0] build_frame(input logic [3:0]  cmd,
                                                     input logic [3:0]  addr,
                                                     input logic [15:0] data16);
    return {8'h00, cmd, addr, data16};
  endfunction

endpackage

// File: rtl/spi_shift32.sv
// 32-bit SPI frame engine: SCK divider, CS framing, shift-out on SCK fall,
// shift-in on SCK rise, start/done handshake with the scheduler.
module spi_shift32
  import dac_spi_pkg::*;
#(
  parameter int SCK_DIV = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [FRAME_W-1:0] frame,
  input  logic               miso,
  output logic               ready,
  output logic               busy,
  output logic               done,
  output logic [FRAME_W-1:0] rx_word,
  output logic               cs_n,
  output logic               sck,
  output logic               mosi
);

  // GAP plus the single IDLE cycle before the next SETUP adds up to two half-periods
  localparam logic [8:0] DIV_LAST = 9'(SCK_DIV - 1);
  localparam logic [8:0] GAP_LAST = 9'(2 * SCK_DIV - 2);

  spi_state_t         state_reg, state_next;
  logic [8:0]         div_reg;
  logic [5:0]         hp_reg;
  logic [FRAME_W-1:0] tx_reg, rx_reg, rx_word_reg;
  logic               done_reg;
  logic               tick, gap_end;

  assign tick    = (div_reg == DIV_LAST);
  assign gap_end = (div_reg == GAP_LAST);

  // State register; async reset drops CS immediately through the output decode
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= ST_IDLE;
    else        state_reg <= state_next;
  end

  // Next-state decode, one half-period per step except the 64-step SHIFT
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:  if (start) state_next = ST_SETUP;
      ST_SETUP: if (tick) state_next = ST_SHIFT;
      ST_SHIFT: if (tick && hp_reg == 6'd63) state_next = ST_HOLD;
      ST_HOLD:  if (tick) state_next = ST_GAP;
      ST_GAP:   if (gap_end) state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // Pin decode: SCK is high on the even SHIFT half-periods (the first one rises)
  always_comb begin
    cs_n  = !(state_reg == ST_SETUP || state_reg == ST_SHIFT || state_reg == ST_HOLD);
    sck   = (state_reg == ST_SHIFT) && !hp_reg[0];
    busy  = (state_reg != ST_IDLE);
    ready = (state_reg == ST_IDLE);
  end

  assign mosi    = tx_reg[FRAME_W-1];
  assign done    = done_reg;
  assign rx_word = rx_word_reg;

  // Divider, half-period counter, shift registers and the end-of-frame pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_reg     <= '0;
      hp_reg      <= '0;
      tx_reg      <= '0;
      rx_reg      <= '0;
      rx_word_reg <= '0;
      done_reg    <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          div_reg <= '0;
          hp_reg  <= '0;
          if (start) tx_reg <= frame;
        end
        ST_SETUP: div_reg <= tick ? 9'd0 : div_reg + 9'd1;
        ST_SHIFT: begin
          // DAC output is captured in the first cycle SCK is high
          if (!hp_reg[0] && div_reg == 9'd0) rx_reg <= {rx_reg[FRAME_W-2:0], miso};
          if (tick) begin
            div_reg <= '0;
            // hp stays at 63 into HOLD so SCK cannot pulse on the transition
            if (hp_reg != 6'd63) hp_reg <= hp_reg + 6'd1;
            // leaving a high half-period is an SCK fall: present the next bit
            if (!hp_reg[0]) tx_reg <= {tx_reg[FRAME_W-2:0], 1'b0};
          end else begin
            div_reg <= div_reg + 9'd1;
          end
        end
        ST_HOLD: begin
          div_reg <= tick ? 9'd0 : div_reg + 9'd1;
          if (tick) begin
            done_reg    <= 1'b1;
            rx_word_reg <= rx_reg;
          end
        end
        ST_GAP:  div_reg <= gap_end ? 9'd0 : div_reg + 9'd1;
        default: div_reg <= '0;
      endcase
    end
  end

endmodule

// File: rtl/dac_spi_multi.sv
// Multi-channel DAC front end: shadow bank, dirty vector, round-robin
// scheduler and frame assembly around the spi_shift32 engine.
module dac_spi_multi
  import dac_spi_pkg::*;
#(
  parameter int         CHANNELS = 4,
  parameter int         DATA_W   = 12,
  parameter int         SCK_DIV  = 2,
  parameter logic [3:0] CMD      = CMD_WRITE_UPDATE,
  localparam int        CH_W     = $clog2(CHANNELS)
) (
  input  logic                CLK50MHZ,
  input  logic                RST,
  input  logic                wr_en,
  input  logic                wr_all,
  input  logic [CH_W-1:0]     wr_ch,
  input  logic [DATA_W-1:0]   wr_data,
  output logic [CHANNELS-1:0] pending,
  output logic                busy,
  output logic                done,
  output logic [CH_W-1:0]     done_ch,
  output logic [31:0]         readback,
  output logic                DAC_CS,
  output logic                DAC_CLR,
  output logic                SPI_SCK,
  output logic                SPI_MOSI,
  input  logic                DAC_OUT
);

  logic [DATA_W-1:0]   shadow_reg [CHANNELS];
  logic [CHANNELS-1:0] pending_reg, pending_next, wr_hit, clr_mask;
  logic [CH_W-1:0]     rr_reg, cur_ch_reg, sel;
  logic [CH_W:0]       idx;
  logic                found, start, ready, wr_ok, clr_reg;
  logic [15:0]         data16;
  logic [FRAME_W-1:0]  frame;

  // Out-of-range channel numbers are dropped
  assign wr_ok = ({1'b0, wr_ch} < (CH_W + 1)'(CHANNELS));

  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_hit
    assign wr_hit[gi] = wr_en && (wr_all || (wr_ok && (wr_ch == CH_W'(gi))));
  end

  // Shadow bank: latest value per channel, coalesced until sent
  always_ff @(posedge CLK50MHZ or negedge RST) begin
    if (!RST) begin
      for (int i = 0; i < CHANNELS; i++) shadow_reg[i] <= '0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) if (wr_hit[i]) shadow_reg[i] <= wr_data;
    end
  end

  // Round-robin pick: first pending channel at or after rr_reg, wrapping
  always_comb begin
    sel   = rr_reg;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      idx = {1'b0, rr_reg} + (CH_W + 1)'(k);
      if (idx >= (CH_W + 1)'(CHANNELS)) idx = idx - (CH_W + 1)'(CHANNELS);
      if (!found && pending_reg[idx[CH_W-1:0]]) begin
        found = 1'b1;
        sel   = idx[CH_W-1:0];
      end
    end
  end

  assign start    = ready && found;
  assign clr_mask = CHANNELS'(start) << sel;
  // A write in the same cycle as the clear re-arms the channel
  assign pending_next = (pending_reg & ~clr_mask) | wr_hit;

  // Frame latched by the engine on SETUP entry, so later writes never corrupt it
  assign data16 = 16'(shadow_reg[sel]) << (16 - DATA_W);
  assign frame  = build_frame(CMD, 4'(sel), data16);

  // Dirty vector, scheduler pointer and the channel of the frame in flight
  always_ff @(posedge CLK50MHZ or negedge RST) begin
    if (!RST) begin
      pending_reg <= '0;
      rr_reg      <= '0;
      cur_ch_reg  <= '0;
    end else begin
      pending_reg <= pending_next;
      if (start) begin
        rr_reg     <= (sel == CH_W'(CHANNELS - 1)) ? '0 : sel + 1'b1;
        cur_ch_reg <= sel;
      end
    end
  end

  // DAC clear held while in reset, released on the first edge afterwards
  always_ff @(posedge CLK50MHZ or negedge RST) begin
    if (!RST) clr_reg <= 1'b0;
    else      clr_reg <= 1'b1;
  end

  spi_shift32 #(.SCK_DIV(SCK_DIV)) u_shift (
    .clk     (CLK50MHZ),
    .rst_n   (RST),
    .start   (start),
    .frame   (frame),
    .miso    (DAC_OUT),
    .ready   (ready),
    .busy    (busy),
    .done    (done),
    .rx_word (readback),
    .cs_n    (DAC_CS),
    .sck     (SPI_SCK),
    .mosi    (SPI_MOSI)
  );

  assign pending = pending_reg;
  assign done_ch = cur_ch_reg;
  assign DAC_CLR = clr_reg;

endmodule

// File: tb/tb_dac_spi_multi.sv
// Directed bench for dac_spi_multi with a DAC model that echoes the previous frame.
module tb_dac_spi_multi;

  localparam int CHANNELS = 4;
  localparam int DATA_W   = 12;
  localparam int SCK_DIV  = 2;
  localparam int CH_W     = 2;
  localparam int PERIOD   = 20;

  logic                clk     = 1'b0;
  logic                rst_n   = 1'b1;
  logic                wr_en   = 1'b0;
  logic                wr_all  = 1'b0;
  logic [CH_W-1:0]     wr_ch   = '0;
  logic [DATA_W-1:0]   wr_data = '0;
  logic [CHANNELS-1:0] pending;
  logic                busy, done;
  logic [CH_W-1:0]     done_ch;
  logic [31:0]         readback;
  logic                dac_cs, dac_clr, spi_sck, spi_mosi;
  logic                dac_out = 1'b0;

  int n_cmp = 0;
  int n_err = 0;

  always #(PERIOD / 2) clk = ~clk;

  dac_spi_multi #(
    .CHANNELS(CHANNELS), .DATA_W(DATA_W), .SCK_DIV(SCK_DIV), .CMD(4'b0011)
  ) dut (
    .CLK50MHZ (clk),
    .RST      (rst_n),
    .wr_en    (wr_en),
    .wr_all   (wr_all),
    .wr_ch    (wr_ch),
    .wr_data  (wr_data),
    .pending  (pending),
    .busy     (busy),
    .done     (done),
    .done_ch  (done_ch),
    .readback (readback),
    .DAC_CS   (dac_cs),
    .DAC_CLR  (dac_clr),
    .SPI_SCK  (spi_sck),
    .SPI_MOSI (spi_mosi),
    .DAC_OUT  (dac_out)
  );

  // Expected frames in the order the scheduler must send them
  logic [31:0]     exp_word [10] = '{32'h0032ABC0, 32'h00301000, 32'h00313330, 32'h00334440,
                                     32'h00335550, 32'h00307FF0, 32'h00317FF0, 32'h00327FF0,
                                     32'h00337FF0, 32'h00300AA0};
  logic [CH_W-1:0] exp_ch [10]   = '{2'd2, 2'd0, 2'd1, 2'd3, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3, 2'd0};

  // Pin monitor plus DAC model: capture MOSI on SCK rise, echo previous word on SCK fall
  logic [31:0] fr_word [$];
  int          fr_len  [$];
  time         fr_fall [$];
  logic        cs_q = 1'b1, sck_q = 1'b0;
  logic [31:0] cap = '0, echo = '0, prev_word = '0;
  int          nbits = 0;
  time         fall_t = 0;

  always @(dac_cs or spi_sck) begin
    if (cs_q === 1'b1 && dac_cs === 1'b0) begin
      fall_t  = $time;
      cap     = '0;
      nbits   = 0;
      echo    = prev_word;
      dac_out = echo[31];
      fr_fall.push_back($time);
    end else if (cs_q === 1'b0 && dac_cs === 1'b1) begin
      if (rst_n === 1'b1 && nbits == 32) begin
        fr_word.push_back(cap);
        fr_len.push_back(int'(($time - fall_t) / PERIOD));
        prev_word = cap;
      end
    end
    if (dac_cs === 1'b0 && sck_q === 1'b0 && spi_sck === 1'b1) begin
      cap   = {cap[30:0], spi_mosi};
      nbits = nbits + 1;
    end
    if (dac_cs === 1'b0 && sck_q === 1'b1 && spi_sck === 1'b0) begin
      echo    = {echo[30:0], 1'b0};
      dac_out = echo[31];
    end
    cs_q  = dac_cs;
    sck_q = spi_sck;
  end

  // Done pulses sampled mid-cycle
  logic [CH_W-1:0] dn_ch [$];
  logic [31:0]     dn_rb [$];

  always @(negedge clk) begin
    if (done === 1'b1) begin
      dn_ch.push_back(done_ch);
      dn_rb.push_back(readback);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wr(input int ch, input logic [DATA_W-1:0] d, input logic all);
    @(posedge clk); #1;
    wr_en = 1'b1; wr_ch = CH_W'(ch); wr_data = d; wr_all = all;
    @(posedge clk); #1;
    wr_en = 1'b0; wr_all = 1'b0;
  endtask

  task automatic wait_dones(input int n, input string tag);
    int k = 0;
    while (dn_ch.size() < n && k < 3000) begin
      @(posedge clk); #1;
      k++;
    end
    @(negedge clk);
    chk(tag, dn_ch.size(), n);
  endtask

  task automatic wait_idle(input string tag);
    int k = 0;
    while ((busy !== 1'b0 || pending !== '0) && k < 5000) begin
      @(posedge clk); #1;
      k++;
    end
    chk(tag, {busy, pending}, '0);
  endtask

  task automatic wait_cs_low(input string tag);
    int k = 0;
    while (dac_cs !== 1'b0 && k < 500) begin
      @(posedge clk); #1;
      k++;
    end
    chk(tag, dac_cs, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    time t_fall;
    int  n_fr;

    // Reset state
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_cs", dac_cs, 1);
    chk("rst_sck", spi_sck, 0);
    chk("rst_mosi", spi_mosi, 0);
    chk("rst_clr", dac_clr, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_pending", pending, 0);
    chk("rst_readback", readback, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("clr_before_edge", dac_clr, 0);
    @(posedge clk); #1;
    chk("clr_after_edge", dac_clr, 1);

    // Single write ch2 = ABC
    wr(2, 12'hABC, 1'b0);
    chk("pend_after_wr", pending, 4'b0100);
    chk("cs_at_edge0", dac_cs, 1);
    @(posedge clk); #1;
    chk("cs_low_edge1", dac_cs, 0);
    chk("busy_edge1", busy, 1);
    chk("pend_clr_setup", pending, 0);
    chk("sck_setup", spi_sck, 0);
    wait_dones(1, "done_single");
    wait_idle("idle_single");
    chk("one_done_pulse", dn_ch.size(), 1);

    // Coalescing: three writes to ch1 while ch0 is in flight
    wr(0, 12'h100, 1'b0);
    repeat (10) @(posedge clk);
    wr(1, 12'h111, 1'b0);
    wr(1, 12'h222, 1'b0);
    wr(1, 12'h333, 1'b0);
    chk("pend_coalesce", pending, 4'b0010);
    wait_dones(3, "done_coalesce");
    wait_idle("idle_coalesce");
    repeat (300) @(posedge clk);
    #1;
    chk("coalesce_frames", fr_word.size(), 3);

    // Write to ch3 during its own frame
    wr(3, 12'h444, 1'b0);
    wait_cs_low("cs_low_own");
    repeat (60) @(posedge clk);
    wr(3, 12'h555, 1'b0);
    chk("pend_own", pending, 4'b1000);
    chk("cs_own_inflight", dac_cs, 0);
    wait_dones(5, "done_own");
    wait_idle("idle_own");
    chk("own_spacing", 32'(int'((fr_fall[4] - fr_fall[3]) / PERIOD)), 136);

    // Round-robin broadcast, ch0 rewritten during ch1's frame
    wr(0, 12'h7FF, 1'b1);
    chk("pend_all", pending, 4'b1111);
    wait_dones(6, "done_rr0");
    repeat (20) @(posedge clk);
    wr(0, 12'h0AA, 1'b0);
    chk("pend_rr_rewrite", pending, 4'b1101);
    wait_dones(10, "done_rr_all");
    wait_idle("idle_rr");
    for (int k = 6; k < 10; k++)
      chk($sformatf("rr_spacing_%0d", k), 32'(int'((fr_fall[k] - fr_fall[k-1]) / PERIOD)), 136);

    // Frame contents, lengths, done channels and echoed readback
    chk("frame_count", fr_word.size(), 10);
    for (int k = 0; k < 10; k++) begin
      chk($sformatf("frame_%0d", k), fr_word[k], exp_word[k]);
      chk($sformatf("cs_len_%0d", k), 32'(fr_len[k]), 132);
      chk($sformatf("done_ch_%0d", k), 32'(dn_ch[k]), 32'(exp_ch[k]));
    end
    chk("readback_0", dn_rb[0], 0);
    for (int k = 1; k < 10; k++)
      chk($sformatf("readback_%0d", k), dn_rb[k], exp_word[k-1]);

    // Reset in the middle of SHIFT
    wr(1, 12'h123, 1'b0);
    wr(2, 12'h321, 1'b0);
    wait_cs_low("cs_low_rst");
    n_fr   = fr_fall.size();
    t_fall = fr_fall[n_fr - 1];
    #(t_fall + 40 * PERIOD + 5 - $time);
    chk("pre_rst_cs", dac_cs, 0);
    chk("pre_rst_pend", pending, 4'b0100);
    rst_n = 1'b0;
    #1;
    chk("midrst_cs", dac_cs, 1);
    chk("midrst_clr", dac_clr, 0);
    chk("midrst_sck", spi_sck, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_pend", pending, 0);
    chk("midrst_readback", readback, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rel_clr_before", dac_clr, 0);
    @(posedge clk); #1;
    chk("rel_clr_after", dac_clr, 1);
    repeat (300) @(posedge clk);
    #1;
    chk("rel_cs_idle", dac_cs, 1);
    chk("rel_busy", busy, 0);
    chk("rel_pend", pending, 0);
    chk("rel_no_done", dn_ch.size(), 10);
    chk("rel_no_frame", fr_word.size(), 10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
